edge_event_arbiter: RTL and testbench

Multi-channel edge/pulse event collector. It runs a configurable edge or one-cycle-pulse detector on each of N input lines and latches every detected event into a per-channel pending flag. A round-robin arbiter then serialises the pending events into a single valid/ready event stream carrying the channel index. It sits between raw status lines and a downstream consumer (interrupt controller, logger) that handles one event per transfer.

---
 rtl/edge_event_arbiter.sv | 178 +++++++++++++++++
 tb/tb_edge_event_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
// Collects edge/pulse events from N raw status lines into per-channel pending
// flags and serialises them, round-robin, into one valid/ready event stream.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   a[N]       raw input lines, channel i on a[i]
//   mode[2N]   per-channel detector: 00 off, 01 rise, 10 fall, 11 pulse (010)
//   evt_valid  event presented on evt_id (registered)
//   evt_id     channel index of the presented event (registered)
//   evt_ready  consumer accepts the presented event
//   pending    per-channel pending flags (registered)
//   ovf        sticky per-channel overflow flags (registered)
//   ovf_clr    one-cycle pulse clearing all ovf bits
module edge_event_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     a,
  input  logic [2*N-1:0]   mode,
  output logic             evt_valid,
  output logic [IDW-1:0]   evt_id,
  input  logic             evt_ready,
  output logic [N-1:0]     pending,
  output logic [N-1:0]     ovf,
  input  logic             ovf_clr
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [N-1:0]     h1_r;
  logic [N-1:0]     h2_r;
  logic [N-1:0]     pending_r;
  logic [N-1:0]     ovf_r;
  logic [IDW-1:0]   evt_id_r;
  logic [IDW-1:0]   rr_ptr_r;

  logic [N-1:0]     detect_s;
  logic [N-1:0]     rot_s;
  logic [IDW-1:0]   grant_off_s;
  logic             any_pend_s;
  logic [IDW:0]     sum_s;
  logic [IDW-1:0]   grant_s;
  logic [IDW:0]     ptr_inc_s;
  logic [IDW-1:0]   ptr_nxt_s;
  logic             load_s;
  logic [N-1:0]     clear_s;
  logic [N-1:0]     ovf_set_s;
  logic             evt_valid_s;

  // Per-channel detector selected by the two mode bits of that channel.
  always_comb begin
    detect_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      case (mode[2*i +: 2])
        2'b00:   detect_s[i] = 1'b0;
        2'b01:   detect_s[i] = a[i] & ~h1_r[i];
        2'b10:   detect_s[i] = ~a[i] & h1_r[i];
        2'b11:   detect_s[i] = ~a[i] & h1_r[i] & ~h2_r[i];
        default: detect_s[i] = 1'b0;
      endcase
    end
  end

  // Rotate pending so that bit 0 is the channel at rr_ptr; the lowest set bit
  // of the rotated vector is then the round-robin winner's offset.
  assign rot_s = N'({pending_r, pending_r} >> rr_ptr_r);

  // Round-robin grant: lowest rotated offset wins, mapped back modulo N.
  always_comb begin
    grant_off_s = {IDW{1'b0}};
    any_pend_s  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      grant_off_s = rot_s[i] ? IDW'(i) : grant_off_s;
      any_pend_s  = any_pend_s | rot_s[i];
    end
    sum_s = {1'b0, rr_ptr_r} + {1'b0, grant_off_s};
    if (sum_s >= (IDW+1)'(N)) begin
      grant_s = IDW'(sum_s - (IDW+1)'(N));
    end else begin
      grant_s = sum_s[IDW-1:0];
    end
    ptr_inc_s = {1'b0, grant_s} + {{IDW{1'b0}}, 1'b1};
    if (ptr_inc_s >= (IDW+1)'(N)) begin
      ptr_nxt_s = {IDW{1'b0}};
    end else begin
      ptr_nxt_s = ptr_inc_s[IDW-1:0];
    end
  end

  // Load when the output slot is free or being handed over, and work exists.
  always_comb begin
    load_s = any_pend_s & ((state_r == ST_EMPTY) | evt_ready);
    if (load_s) begin
      clear_s = {{(N-1){1'b0}}, 1'b1} << grant_s;
    end else begin
      clear_s = {N{1'b0}};
    end
    // A new event on a bit that stays pending merges and is flagged.
    ovf_set_s = detect_s & pending_r & ~clear_s;
  end

  // Output-slot state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output-slot next state: load fills, an unrefilled transfer empties.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: state_nxt_s = load_s ? ST_FULL : ST_EMPTY;
      ST_FULL: begin
        if (load_s) begin
          state_nxt_s = ST_FULL;
        end else if (evt_ready) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Output-slot decode; depends only on the state register.
  always_comb begin
    case (state_r)
      ST_EMPTY: evt_valid_s = 1'b0;
      ST_FULL:  evt_valid_s = 1'b1;
      default:  evt_valid_s = 1'b0;
    endcase
  end

  // History, pending/overflow flags, presented id and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      h1_r      <= {N{1'b0}};
      h2_r      <= {N{1'b0}};
      pending_r <= {N{1'b0}};
      ovf_r     <= {N{1'b0}};
      evt_id_r  <= {IDW{1'b0}};
      rr_ptr_r  <= {IDW{1'b0}};
    end else begin
      h1_r      <= a;
      h2_r      <= h1_r;
      // Same-edge detection on the granted channel keeps the new event.
      pending_r <= (pending_r & ~clear_s) | detect_s;
      // Overflow set wins over a simultaneous clear.
      ovf_r     <= (ovf_clr ? {N{1'b0}} : ovf_r) | ovf_set_s;
      if (load_s) begin
        evt_id_r <= grant_s;
        rr_ptr_r <= ptr_nxt_s;
      end else begin
        evt_id_r <= evt_id_r;
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  assign evt_valid = evt_valid_s;
  assign evt_id    = evt_id_r;
  assign pending   = pending_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: a behavioural model predicts every
// granted event id (queued) and the per-cycle flag state; a separate monitor
// pops the queue on every observed transfer.
module tb_edge_event_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     a;
  logic [2*N-1:0]   mode;
  logic             evt_valid;
  logic [IDW-1:0]   evt_id;
  logic             evt_ready;
  logic [N-1:0]     pending;
  logic [N-1:0]     ovf;
  logic             ovf_clr;

  edge_event_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .a(a), .mode(mode),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_ready(evt_ready),
    .pending(pending), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int got_q[$];

  // Reference model state: last two samples of each line, pending/overflow
  // sets, whether an event is on offer, its id and the search start.
  bit m_prev1[N];
  bit m_prev2[N];
  bit m_pend[N];
  bit m_ovf[N];
  bit m_full;
  int m_id;
  int m_ptr;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int vec(input bit v[N]);
    int r = 0;
    for (int i = 0; i < N; i++) r = r | (int'(v[i]) << i);
    return r;
  endfunction

  task automatic model_step(input bit r, input logic [N-1:0] av,
                            input logic [2*N-1:0] mv, input bit rdy, input bit clr);
    bit det[N];
    int g;
    if (r) begin
      if (m_full && exp_q.size() > 0) void'(exp_q.pop_back());
      for (int i = 0; i < N; i++) begin
        m_prev1[i] = 0; m_prev2[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
      end
      m_full = 0; m_id = 0; m_ptr = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      case (int'(mv[2*i +: 2]))
        1: det[i] = av[i] && !m_prev1[i];
        2: det[i] = !av[i] && m_prev1[i];
        3: det[i] = !av[i] && m_prev1[i] && !m_prev2[i];
        default: det[i] = 0;
      endcase
    end
    g = -1;
    if (!m_full || rdy)
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    for (int i = 0; i < N; i++) begin
      bit ov;
      ov = det[i] && m_pend[i] && (g != i);
      m_ovf[i]  = (clr ? 1'b0 : m_ovf[i]) | ov;
      m_pend[i] = (m_pend[i] && (g != i)) || det[i];
      m_prev2[i] = m_prev1[i];
      m_prev1[i] = av[i];
    end
    if (g >= 0) begin
      m_full = 1; m_id = g; m_ptr = (g + 1) % N;
      exp_q.push_back(g);
    end else if (m_full && rdy) begin
      m_full = 0;
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input bit r, input logic [N-1:0] av,
                      input logic [2*N-1:0] mv, input bit rdy, input bit clr);
    rst = r; a = av; mode = mv; evt_ready = rdy; ovf_clr = clr;
    model_step(r, av, mv, rdy, clr);
    @(posedge clk);
    #1;
    check("evt_valid", evt_valid, int'(m_full));
    check("evt_id", evt_id, m_id);
    check("pending", pending, vec(m_pend));
    check("ovf", ovf, vec(m_ovf));
  endtask

  // Monitor: every accepted transfer must match the oldest predicted grant.
  always @(negedge clk) begin
    int e;
    if (rst === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      got_q.push_back(int'(evt_id));
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_unexpected: got id %0d expected no event", evt_id);
      end else begin
        e = exp_q.pop_front();
        check("scoreboard_id", evt_id, e);
      end
    end
  end

  initial begin
    logic [N-1:0]   ra;
    logic [2*N-1:0] rm;
    int pseq[7];
    int dseq[7];
    int rseq[9];
    pseq = '{0, 0, 4, 0, 0, 0, 0};
    dseq = '{0, 4, 4, 0, 0, 0, 0};
    rseq = '{0, 10, 10, 10, 0, 10, 10, 10, 0};

    // Reset with all lines high and all channels rising: 0,1,2,3 afterwards.
    step(1'b1, 4'hF, 8'h55, 1'b1, 1'b0);
    step(1'b1, 4'hF, 8'h55, 1'b1, 1'b0);
    got_q.delete();
    repeat (6) step(1'b0, 4'hF, 8'h55, 1'b1, 1'b0);
    check("reset_order_count", got_q.size(), 4);
    for (int k = 0; k < 4 && k < got_q.size(); k++) check("reset_order_id", got_q[k], k);

    // Pulse on ch2: 0,1,0 fires once; 0,1,1,0 does not; falling mode does.
    got_q.delete();
    for (int k = 0; k < 7; k++) step(1'b0, 4'(pseq[k]), 8'h30, 1'b1, 1'b0);
    check("pulse_010_count", got_q.size(), 1);
    if (got_q.size() > 0) check("pulse_010_id", got_q[0], 2);
    got_q.delete();
    for (int k = 0; k < 7; k++) step(1'b0, 4'(dseq[k]), 8'h30, 1'b1, 1'b0);
    check("pulse_0110_count", got_q.size(), 0);
    got_q.delete();
    for (int k = 0; k < 7; k++) step(1'b0, 4'(dseq[k]), 8'h20, 1'b1, 1'b0);
    check("fall_0110_count", got_q.size(), 1);

    // Round-robin from a fresh pointer: ch1 and ch3 rise together, twice.
    step(1'b1, 4'h0, 8'h44, 1'b1, 1'b0);
    got_q.delete();
    for (int k = 0; k < 9; k++) step(1'b0, 4'(rseq[k]), 8'h44, 1'b1, 1'b0);
    check("rr_count", got_q.size(), 4);
    for (int k = 0; k < 4 && k < got_q.size(); k++)
      check("rr_order", got_q[k], (k % 2 == 0) ? 1 : 3);

    // Backpressure on ch0: refill, then overflow, clear, clear-vs-set.
    step(1'b1, 4'h0, 8'h01, 1'b0, 1'b0);
    step(1'b0, 4'h0, 8'h01, 1'b0, 1'b0);
    step(1'b0, 4'h1, 8'h01, 1'b0, 1'b0);
    step(1'b0, 4'h0, 8'h01, 1'b0, 1'b0);
    step(1'b0, 4'h1, 8'h01, 1'b0, 1'b0);
    step(1'b0, 4'h0, 8'h01, 1'b0, 1'b0);
    step(1'b0, 4'h1, 8'h01, 1'b0, 1'b0);
    check("ovf_set", ovf, 1);
    check("held_id", evt_id, 0);
    step(1'b0, 4'h0, 8'h01, 1'b0, 1'b1);
    check("ovf_cleared", ovf, 0);
    step(1'b0, 4'h1, 8'h01, 1'b0, 1'b1);
    check("ovf_set_wins", ovf, 1);

    // Mid-stream reset with ch1/ch3 also pending: everything is discarded.
    step(1'b0, 4'hA, 8'h45, 1'b0, 1'b0);
    check("pre_reset_pending", pending, 4'hB);
    got_q.delete();
    step(1'b1, 4'h0, 8'h45, 1'b1, 1'b0);
    check("mid_reset_valid", evt_valid, 0);
    check("mid_reset_pending", pending, 0);
    check("mid_reset_ovf", ovf, 0);
    repeat (5) step(1'b0, 4'h0, 8'h45, 1'b1, 1'b0);
    check("no_stale_event", got_q.size(), 0);

    // Randomised traffic against the model.
    rm = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) rm = 8'($urandom);
      ra = 4'($urandom);
      step(($urandom_range(0, 199) == 0), ra, rm,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
